prom_bus_arbiter: RTL and testbench
===================================

Name: prom_bus_arbiter

Overview:
- Sequences the 1024x32 synchronous program ROM (Gowin pROM, bypass read mode, 1-cycle read latency) and shares it between two readers.
- Requester 1 is the PicoRV32 native memory port (byte address, valid/ready). Requester 2 is an auxiliary word-address reader, e.g. a UART ROM-dump or CRC self-check engine.
- Drives the ROM's ce/oce/reset/ad pins and returns registered read data with a one-cycle ready pulse.
- Flags illegal writes and out-of-range CPU accesses.

Parameters:
- BASE_ADDR, 32'h0000_0000, CPU byte-address base of the ROM window. Must be aligned to 2^(ADDR_BITS+2).
- ADDR_BITS, 10, ROM word-address width. The window size is 2^(ADDR_BITS+2) bytes.
- AUX_MAX_WAIT, 4, maximum consecutive CPU grants allowed while aux_valid is pending. Range 1..15.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- cpu_valid  in  1  CPU request; held until cpu_ready.
- cpu_addr  in  32  CPU byte address.
- cpu_wstrb  in  4  CPU write strobes; non-zero means a write.
- cpu_ready  out  1  one-cycle completion pulse.
- cpu_rdata  out  32  read data, valid while cpu_ready=1.
- aux_valid  in  1  aux request; held until aux_ready.
- aux_addr  in  ADDR_BITS  aux word address.
- aux_ready  out  1  one-cycle completion pulse.
- aux_rdata  out  32  read data, valid while aux_ready=1.
- rom_ce  out  1  ROM clock enable.
- rom_oce  out  1  ROM output clock enable; constant 1.
- rom_reset  out  1  ROM synchronous reset; equals reset.
- rom_ad  out  ADDR_BITS  ROM word address, registered.
- rom_dout  in  32  ROM read data.
- wr_err  out  1  sticky: CPU write attempted.
- range_err  out  1  sticky: CPU address outside the window.
- err_clr  in  1  clears wr_err and range_err.

Behaviour:
- Reset values: cpu_ready=0, aux_ready=0, cpu_rdata=0, aux_rdata=0, rom_ce=0, rom_ad=0, wr_err=0, range_err=0, starvation counter=0, state=IDLE.
- States: IDLE, ISSUE, CAPTURE, DONE.
- IDLE, arbitration:
  - Eligible requester = valid high and its ready not high this cycle.
  - CPU wins by fixed priority, except aux wins when aux is eligible and the starvation counter equals AUX_MAX_WAIT.
  - Counter increments on each CPU grant while aux_valid=1, and clears on each aux grant.
  - On grant, latch grant_id and register rom_ad. The CPU address is cpu_addr[ADDR_BITS+1:2]; the aux address is aux_addr.
- CPU special cases, checked in IDLE before a ROM access:
  - If cpu_wstrb!=0: no ROM access, set wr_err, go to DONE with cpu_rdata=0.
  - Else if cpu_addr[31:ADDR_BITS+2] != BASE_ADDR[31:ADDR_BITS+2]: no ROM access, set range_err, go to DONE with cpu_rdata=0.
  - If both conditions hold, only wr_err is set.
  - cpu_addr[1:0] is ignored; all reads are word reads.
- ISSUE: rom_ce=1 for exactly this one cycle. rom_ce is 0 in every other state.
- CAPTURE: rom_dout is valid. Register it into the granted requester's rdata; the other rdata holds its value.
- DONE: the granted ready is 1 for exactly one cycle, then the state returns to IDLE.
- Latency and throughput:
  - ROM read: request sampled in IDLE at cycle T; ready high at T+3.
  - Error/write ack: ready high at T+1.
  - Next grant is possible at T+4.
- cpu_ready and aux_ready are never high in the same cycle.
- A requester dropping valid after grant does not abort the access; the ready pulse is still issued.
- wr_err/range_err: err_clr clears both. If a set event and err_clr coincide, set wins.
- Reset mid-operation: return to IDLE immediately with no ready pulse. rom_ce deasserts the same cycle reset is sampled. The pending request is re-arbitrated after reset if still valid.
- rom_ad holds its last value while IDLE. No combinational path from inputs to ROM pins.

Test Plan:
- ROM model preloaded with mem[a] = 32'hA5A5_0000 | a. CPU read of 0x0000_0010 (word 4) -> rom_ad=4, a single rom_ce pulse at T+1, cpu_ready at T+3 with cpu_rdata=32'hA5A5_0004, aux_ready stays 0.
- CPU write: cpu_addr=0x0000_0000, cpu_wstrb=4'hF -> cpu_ready at T+1, cpu_rdata=0, wr_err=1, rom_ce never asserted. Then err_clr=1 for one cycle -> wr_err=0.
- Out of range: cpu_addr=0x0000_1000 -> cpu_ready at T+1, rdata=0, range_err=1. cpu_addr=0x0000_0FFC -> rdata=32'hA5A5_03FF, no error.
- Contention: cpu_valid and aux_valid held continuously, aux_addr=10'h155, AUX_MAX_WAIT=4 -> grant order CPU,CPU,CPU,CPU,AUX repeating. aux_rdata=32'hA5A5_0155, grants spaced 4 cycles apart.
- Reset asserted in the ISSUE cycle of a CPU read -> no cpu_ready pulse, rom_ce=0 next cycle, all outputs at reset values. After reset drops with cpu_valid still high, the read completes 3 cycles after the first IDLE sample.
- Back-to-back aux reads with addresses 0, 1, 0x3FF -> aux_ready pulses 4 cycles apart, rdata 32'hA5A5_0000, 32'hA5A5_0001, 32'hA5A5_03FF. No duplicate access while aux_ready is high.

Source files
------------

// File: rtl/prom_bus_arbiter_if.sv
// Request/response bundle for the two program-ROM readers: the CPU native
// memory port (byte address, valid/ready) and the auxiliary word-address reader.
interface prom_bus_arbiter_if #(
    parameter int ADDR_BITS = 10
);
    logic                 cpu_valid;
    logic [31:0]          cpu_addr;
    logic [3:0]           cpu_wstrb;
    logic                 cpu_ready;
    logic [31:0]          cpu_rdata;
    logic                 aux_valid;
    logic [ADDR_BITS-1:0] aux_addr;
    logic                 aux_ready;
    logic [31:0]          aux_rdata;

    modport master (
        output cpu_valid, cpu_addr, cpu_wstrb, aux_valid, aux_addr,
        input  cpu_ready, cpu_rdata, aux_ready, aux_rdata
    );

    modport slave (
        input  cpu_valid, cpu_addr, cpu_wstrb, aux_valid, aux_addr,
        output cpu_ready, cpu_rdata, aux_ready, aux_rdata
    );
endinterface

// File: rtl/prom_bus_arbiter.sv
// Shares a 1-cycle-latency synchronous program ROM between the CPU and an aux
// reader: fixed CPU priority with an aux starvation limit, sticky error flags.
module prom_bus_arbiter #(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter int          ADDR_BITS    = 10,
    parameter int          AUX_MAX_WAIT = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    prom_bus_arbiter_if.slave    bus,
    output logic                 rom_ce,
    output logic                 rom_oce,
    output logic                 rom_reset,
    output logic [ADDR_BITS-1:0] rom_ad,
    input  logic [31:0]          rom_dout,
    output logic                 wr_err,
    output logic                 range_err,
    input  logic                 err_clr
);
    localparam int         TAG_LSB  = ADDR_BITS + 2;
    localparam logic [3:0] MAX_WAIT = 4'(AUX_MAX_WAIT);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t               state_r;
    logic                 grant_aux_r;
    logic [3:0]           starve_cnt_r;
    logic                 rom_ce_r;
    logic [ADDR_BITS-1:0] rom_ad_r;
    logic                 cpu_ready_r;
    logic                 aux_ready_r;
    logic [31:0]          cpu_rdata_r;
    logic [31:0]          aux_rdata_r;
    logic                 wr_err_r;
    logic                 range_err_r;

    logic                 cpu_elig_s;
    logic                 aux_elig_s;
    logic                 pick_aux_s;
    logic                 cpu_write_s;
    logic                 cpu_oor_s;
    logic [1:0]           unused_addr_lsb_s;

    // Reads are always whole words; the byte offset is deliberately dropped.
    assign unused_addr_lsb_s = bus.cpu_addr[1:0];

    // Arbitration and CPU request classification for the IDLE decision.
    always_comb begin
        cpu_elig_s  = bus.cpu_valid & ~cpu_ready_r;
        aux_elig_s  = bus.aux_valid & ~aux_ready_r;
        cpu_write_s = (bus.cpu_wstrb != 4'h0);
        cpu_oor_s   = (bus.cpu_addr[31:TAG_LSB] != BASE_ADDR[31:TAG_LSB]);
        if (aux_elig_s && (!cpu_elig_s || (starve_cnt_r == MAX_WAIT))) begin
            pick_aux_s = 1'b1;
        end else begin
            pick_aux_s = 1'b0;
        end
    end

    // Access sequencer: grant, ROM enable pulse, data capture, ready pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= IDLE;
            grant_aux_r  <= 1'b0;
            starve_cnt_r <= 4'd0;
            rom_ce_r     <= 1'b0;
            rom_ad_r     <= '0;
            cpu_ready_r  <= 1'b0;
            aux_ready_r  <= 1'b0;
            cpu_rdata_r  <= 32'h0000_0000;
            aux_rdata_r  <= 32'h0000_0000;
            wr_err_r     <= 1'b0;
            range_err_r  <= 1'b0;
        end else begin
            cpu_ready_r <= 1'b0;
            aux_ready_r <= 1'b0;
            rom_ce_r    <= 1'b0;
            // Clear first so a same-cycle error set below takes precedence.
            if (err_clr) begin
                wr_err_r    <= 1'b0;
                range_err_r <= 1'b0;
            end
            case (state_r)
                IDLE: begin
                    if (pick_aux_s) begin
                        grant_aux_r  <= 1'b1;
                        starve_cnt_r <= 4'd0;
                        rom_ad_r     <= bus.aux_addr;
                        rom_ce_r     <= 1'b1;
                        state_r      <= ISSUE;
                    end else if (cpu_elig_s) begin
                        grant_aux_r <= 1'b0;
                        if (bus.aux_valid) begin
                            starve_cnt_r <= starve_cnt_r + 4'd1;
                        end
                        if (cpu_write_s) begin
                            wr_err_r    <= 1'b1;
                            cpu_rdata_r <= 32'h0000_0000;
                            cpu_ready_r <= 1'b1;
                            state_r     <= DONE;
                        end else if (cpu_oor_s) begin
                            range_err_r <= 1'b1;
                            cpu_rdata_r <= 32'h0000_0000;
                            cpu_ready_r <= 1'b1;
                            state_r     <= DONE;
                        end else begin
                            rom_ad_r <= bus.cpu_addr[ADDR_BITS+1:2];
                            rom_ce_r <= 1'b1;
                            state_r  <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    state_r <= CAPTURE;
                end
                CAPTURE: begin
                    if (grant_aux_r) begin
                        aux_rdata_r <= rom_dout;
                        aux_ready_r <= 1'b1;
                    end else begin
                        cpu_rdata_r <= rom_dout;
                        cpu_ready_r <= 1'b1;
                    end
                    state_r <= DONE;
                end
                DONE: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign bus.cpu_ready = cpu_ready_r;
    assign bus.cpu_rdata = cpu_rdata_r;
    assign bus.aux_ready = aux_ready_r;
    assign bus.aux_rdata = aux_rdata_r;
    assign rom_ce        = rom_ce_r;
    assign rom_oce       = 1'b1;
    assign rom_reset     = reset;
    assign rom_ad        = rom_ad_r;
    assign wr_err        = wr_err_r;
    assign range_err     = range_err_r;

endmodule

// File: tb/tb_prom_bus_arbiter.sv
// Scoreboard bench for prom_bus_arbiter: drivers queue expected responses
// (requester, data, completion cycle); a negedge monitor pops and compares.
module tb_prom_bus_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rom_ce, rom_oce, rom_reset;
    logic [9:0]  rom_ad;
    logic [31:0] rom_dout;
    logic        wr_err, range_err;
    logic        err_clr = 1'b0;
    logic [31:0] rom_q = 32'h0000_0000;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int ce_cnt = 0;

    typedef struct {
        logic        is_aux;
        logic [31:0] data;
        int          cyc;
    } exp_t;
    exp_t sb[$];

    prom_bus_arbiter_if #(.ADDR_BITS(10)) bus();

    prom_bus_arbiter #(
        .BASE_ADDR   (32'h0000_0000),
        .ADDR_BITS   (10),
        .AUX_MAX_WAIT(4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus.slave),
        .rom_ce   (rom_ce),
        .rom_oce  (rom_oce),
        .rom_reset(rom_reset),
        .rom_ad   (rom_ad),
        .rom_dout (rom_dout),
        .wr_err   (wr_err),
        .range_err(range_err),
        .err_clr  (err_clr)
    );

    always #5 clk = ~clk;

    // Cycle counter: value k holds during the cycle following posedge k.
    always @(posedge clk) cyc <= cyc + 1;

    // ROM model, mem[a] = A5A5_0000 | a, one-cycle read latency.
    always @(posedge clk) begin
        if (rom_ce) rom_q <= 32'hA5A5_0000 | {22'd0, rom_ad};
    end
    assign rom_dout = rom_q;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: counts ROM enables and checks each ready pulse against the queue.
    initial forever begin
        @(negedge clk);
        if (rom_ce) ce_cnt++;
        if (bus.cpu_ready && bus.aux_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL dual_ready: both readys high at cycle %0d, expected at most one", cyc);
        end
        if (bus.cpu_ready || bus.aux_ready) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_ready: cpu_ready=%b aux_ready=%b at cycle %0d, expected none",
                         bus.cpu_ready, bus.aux_ready, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("ready_owner(1=aux)", {31'd0, bus.aux_ready}, {31'd0, e.is_aux});
                chk("rdata", bus.aux_ready ? bus.aux_rdata : bus.cpu_rdata, e.data);
                chk("ready_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic wait_empty();
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (sb.size() == 0) return;
        end
        vectors++;
        miscompares++;
        $display("FAIL timeout: %0d responses pending, expected 0", sb.size());
        sb.delete();
    endtask

    task automatic cpu_req(input logic [31:0] a, input logic [3:0] ws, input logic [31:0] d, input int lat);
        @(posedge clk); #1;
        bus.cpu_valid = 1'b1;
        bus.cpu_addr  = a;
        bus.cpu_wstrb = ws;
        sb.push_back('{1'b0, d, cyc + lat});
        wait_empty();
        bus.cpu_valid = 1'b0;
        bus.cpu_wstrb = 4'h0;
    endtask

    task automatic clear_errs();
        @(posedge clk); #1 err_clr = 1'b1;
        @(posedge clk); #1 err_clr = 1'b0;
    endtask

    initial begin
        int ce0;
        logic [9:0] aux_list [3];
        bus.cpu_valid = 1'b0;
        bus.cpu_addr  = 32'h0;
        bus.cpu_wstrb = 4'h0;
        bus.aux_valid = 1'b0;
        bus.aux_addr  = 10'h0;
        aux_list[0] = 10'h000;
        aux_list[1] = 10'h001;
        aux_list[2] = 10'h3FF;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_cpu_ready", {31'd0, bus.cpu_ready}, 32'd0);
        chk("rst_aux_ready", {31'd0, bus.aux_ready}, 32'd0);
        chk("rst_rom_ce", {31'd0, rom_ce}, 32'd0);
        chk("rst_rom_ad", {22'd0, rom_ad}, 32'd0);
        chk("rst_cpu_rdata", bus.cpu_rdata, 32'd0);
        chk("rst_errs", {30'd0, wr_err, range_err}, 32'd0);
        chk("rom_oce", {31'd0, rom_oce}, 32'd1);
        chk("rom_reset_follows", {31'd0, rom_reset}, 32'd1);
        reset = 1'b0;

        // CPU read of word 4: single enable pulse one cycle after the grant.
        ce0 = ce_cnt;
        @(posedge clk); #1;
        bus.cpu_valid = 1'b1;
        bus.cpu_addr  = 32'h0000_0010;
        sb.push_back('{1'b0, 32'hA5A5_0004, cyc + 3});
        @(posedge clk); #1;
        chk("read_rom_ce_T1", {31'd0, rom_ce}, 32'd1);
        chk("read_rom_ad", {22'd0, rom_ad}, 32'd4);
        wait_empty();
        bus.cpu_valid = 1'b0;
        chk("read_ce_pulses", ce_cnt - ce0, 32'd1);

        // CPU write: immediate ack, no ROM access, sticky wr_err, then cleared.
        ce0 = ce_cnt;
        cpu_req(32'h0000_0000, 4'hF, 32'h0, 1);
        chk("write_ce_pulses", ce_cnt - ce0, 32'd0);
        chk("write_wr_err", {31'd0, wr_err}, 32'd1);
        clear_errs();
        chk("clr_wr_err", {31'd0, wr_err}, 32'd0);

        // Just past the window, then the last word inside it.
        cpu_req(32'h0000_1000, 4'h0, 32'h0, 1);
        chk("oor_range_err", {31'd0, range_err}, 32'd1);
        chk("oor_wr_err", {31'd0, wr_err}, 32'd0);
        clear_errs();
        cpu_req(32'h0000_0FFC, 4'h0, 32'hA5A5_03FF, 3);
        chk("top_word_errs", {30'd0, wr_err, range_err}, 32'd0);

        // Write outside the window flags only the write error.
        cpu_req(32'h0000_1000, 4'h1, 32'h0, 1);
        chk("both_err_flags", {30'd0, wr_err, range_err}, 32'd2);
        clear_errs();

        // Error set coinciding with err_clr: the set wins.
        @(posedge clk); #1;
        err_clr = 1'b1;
        bus.cpu_valid = 1'b1;
        bus.cpu_addr  = 32'h0000_0004;
        bus.cpu_wstrb = 4'h3;
        sb.push_back('{1'b0, 32'h0, cyc + 1});
        @(posedge clk); #1;
        chk("set_beats_clr", {31'd0, wr_err}, 32'd1);
        err_clr = 1'b0;
        wait_empty();
        bus.cpu_valid = 1'b0;
        bus.cpu_wstrb = 4'h0;
        clear_errs();

        // Back-to-back aux reads with valid held: completions four cycles apart.
        @(posedge clk); #1;
        bus.aux_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.aux_addr = aux_list[i];
            sb.push_back('{1'b1, 32'hA5A5_0000 | {22'd0, aux_list[i]}, cyc + 3});
            wait_empty();
        end
        bus.aux_valid = 1'b0;

        // Contention: four CPU grants then one aux grant, repeating.
        @(posedge clk); #1;
        bus.cpu_valid = 1'b1;
        bus.cpu_addr  = 32'h0000_0020;
        bus.aux_valid = 1'b1;
        bus.aux_addr  = 10'h155;
        for (int g = 0; g < 10; g++) begin
            if ((g % 5) == 4) sb.push_back('{1'b1, 32'hA5A5_0155, cyc + 4 * g + 3});
            else              sb.push_back('{1'b0, 32'hA5A5_0008, cyc + 4 * g + 3});
        end
        wait_empty();
        bus.cpu_valid = 1'b0;
        bus.aux_valid = 1'b0;

        // Reset in the ISSUE cycle of a CPU read; request re-arbitrated afterwards.
        @(posedge clk); #1;
        bus.cpu_valid = 1'b1;
        bus.cpu_addr  = 32'h0000_0008;
        @(posedge clk); #1;
        chk("rst_mid_issue_ce", {31'd0, rom_ce}, 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid_rom_ce", {31'd0, rom_ce}, 32'd0);
        chk("rst_mid_ready", {30'd0, bus.cpu_ready, bus.aux_ready}, 32'd0);
        chk("rst_mid_cpu_rdata", bus.cpu_rdata, 32'd0);
        chk("rst_mid_aux_rdata", bus.aux_rdata, 32'd0);
        chk("rst_mid_rom_ad", {22'd0, rom_ad}, 32'd0);
        reset = 1'b0;
        sb.push_back('{1'b0, 32'hA5A5_0002, cyc + 3});
        wait_empty();
        bus.cpu_valid = 1'b0;
        repeat (4) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
